// File: rtl/window_2x2_gen_if.sv
// Pixel-stream bundle for the 2x2 window generator: incoming stream, delayed
// syncs and the four window taps.
interface window_2x2_gen_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  pre_img_vsync;
    logic                  pre_img_hsync;
    logic                  pre_img_valid;
    logic [DATA_WIDTH-1:0] pre_img_data;

    logic                  post_img_vsync;
    logic                  post_img_hsync;
    logic                  post_img_valid;
    logic [DATA_WIDTH-1:0] matrix_p11;
    logic [DATA_WIDTH-1:0] matrix_p12;
    logic [DATA_WIDTH-1:0] matrix_p21;
    logic [DATA_WIDTH-1:0] matrix_p22;

    modport master (
        output pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_data,
        input  post_img_vsync, post_img_hsync, post_img_valid,
        input  matrix_p11, matrix_p12, matrix_p21, matrix_p22
    );

    modport slave (
        input  pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_data,
        output post_img_vsync, post_img_hsync, post_img_valid,
        output matrix_p11, matrix_p12, matrix_p21, matrix_p22
    );
endinterface

// File: rtl/window_2x2_gen.sv
// 2x2 sliding-window generator: one line buffer, two-stage pipeline, edge
// replication on the top row and left column.
module window_2x2_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned H_DISP     = 800,
    parameter int unsigned V_DISP     = 600
) (
    input logic             clk,
    input logic             rst_n,
    window_2x2_gen_if.slave img
);
    localparam int unsigned COL_W = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam int unsigned ROW_W = (V_DISP > 1) ? $clog2(V_DISP) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_DISP - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_DISP - 1);

    logic [DATA_WIDTH-1:0] line_mem [H_DISP];

    logic                  hs_prev_q, hs_prev_d;
    logic                  vs_prev_q, vs_prev_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_cur;
    logic [ROW_W-1:0]      row_cur;
    logic                  hs_rise, vs_rise;

    logic [DATA_WIDTH-1:0] s1_pix_q, s1_pix_d;
    logic [DATA_WIDTH-1:0] s1_rd_q, s1_rd_d;
    logic                  s1_col0_q, s1_col0_d;
    logic                  s1_row0_q, s1_row0_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_hs_q, s1_hs_d;
    logic                  s1_vs_q, s1_vs_d;

    logic                  out_valid_q, out_valid_d;
    logic                  out_hs_q, out_hs_d;
    logic                  out_vs_q, out_vs_d;
    logic [DATA_WIDTH-1:0] p11_q, p11_d;
    logic [DATA_WIDTH-1:0] p12_q, p12_d;
    logic [DATA_WIDTH-1:0] p21_q, p21_d;
    logic [DATA_WIDTH-1:0] p22_q, p22_d;

    // A sync rising edge clears the counters in the same cycle, so a pixel
    // arriving with it is already addressed as column 0.
    always_comb begin
        hs_rise   = img.pre_img_hsync & ~hs_prev_q;
        vs_rise   = img.pre_img_vsync & ~vs_prev_q;
        hs_prev_d = img.pre_img_hsync;
        vs_prev_d = img.pre_img_vsync;
        col_cur   = (hs_rise | vs_rise) ? '0 : col_q;
        row_cur   = vs_rise ? '0 : row_q;
        col_d     = col_cur;
        row_d     = row_cur;
        if (img.pre_img_valid) begin
            if (col_cur == COL_LAST) begin
                col_d = '0;
                if (row_cur != ROW_LAST) begin
                    row_d = row_cur + ROW_W'(1);
                end
            end else begin
                col_d = col_cur + COL_W'(1);
            end
        end
    end

    always_comb begin
        s1_pix_d   = img.pre_img_data;
        s1_rd_d    = line_mem[col_cur];
        s1_col0_d  = (col_cur == '0);
        s1_row0_d  = (row_cur == '0);
        s1_valid_d = img.pre_img_valid;
        s1_hs_d    = img.pre_img_hsync;
        s1_vs_d    = img.pre_img_vsync;
    end

    // Left-edge replication takes the freshly computed right column, not the
    // held one, so the first window of a line never shows the previous line.
    always_comb begin
        out_valid_d = s1_valid_q;
        out_hs_d    = s1_hs_q;
        out_vs_d    = s1_vs_q;
        p11_d       = p11_q;
        p12_d       = p12_q;
        p21_d       = p21_q;
        p22_d       = p22_q;
        if (s1_valid_q) begin
            p22_d = s1_pix_q;
            p12_d = s1_row0_q ? s1_pix_q : s1_rd_q;
            p21_d = s1_col0_q ? p22_d : p22_q;
            p11_d = s1_col0_q ? p12_d : p12_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && img.pre_img_valid) begin
            line_mem[col_cur] <= img.pre_img_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            s1_pix_q    <= '0;
            s1_rd_q     <= '0;
            s1_col0_q   <= 1'b0;
            s1_row0_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_hs_q     <= 1'b0;
            s1_vs_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_hs_q    <= 1'b0;
            out_vs_q    <= 1'b0;
            p11_q       <= '0;
            p12_q       <= '0;
            p21_q       <= '0;
            p22_q       <= '0;
        end else begin
            hs_prev_q   <= hs_prev_d;
            vs_prev_q   <= vs_prev_d;
            col_q       <= col_d;
            row_q       <= row_d;
            s1_pix_q    <= s1_pix_d;
            s1_rd_q     <= s1_rd_d;
            s1_col0_q   <= s1_col0_d;
            s1_row0_q   <= s1_row0_d;
            s1_valid_q  <= s1_valid_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            out_valid_q <= out_valid_d;
            out_hs_q    <= out_hs_d;
            out_vs_q    <= out_vs_d;
            p11_q       <= p11_d;
            p12_q       <= p12_d;
            p21_q       <= p21_d;
            p22_q       <= p22_d;
        end
    end

    assign img.post_img_valid = out_valid_q;
    assign img.post_img_hsync = out_hs_q;
    assign img.post_img_vsync = out_vs_q;
    assign img.matrix_p11     = p11_q;
    assign img.matrix_p12     = p12_q;
    assign img.matrix_p21     = p21_q;
    assign img.matrix_p22     = p22_q;
endmodule

// File: tb/tb_window_2x2_gen.sv
// Bench for window_2x2_gen: directed frames with pixel = 10*row+col plus
// randomized frames, all checked against an image-level neighbour model.
module tb_window_2x2_gen;
    localparam int unsigned DW   = 8;
    localparam int unsigned HD   = 4;
    localparam int unsigned VD   = 3;
    localparam int unsigned MAXC = 20000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_2x2_gen_if #(.DATA_WIDTH(DW)) bus ();

    window_2x2_gen #(
        .DATA_WIDTH(DW),
        .H_DISP    (HD),
        .V_DISP    (VD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .img  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: image-level neighbours. Up = last pixel seen in this column
    // (self on row 0), left = previously accepted pixel (self on column 0).
    int          m_col, m_row;
    bit          m_hs_prev, m_vs_prev;
    int          lb [HD];
    int          w11, w12, w21, w22;
    logic [34:0] exp_tab [MAXC];
    int          cyc = 0;
    bit          log_en = 1'b0;
    logic [31:0] log_q [$];

    initial begin
        bit          vs, hs, v;
        int          d, up;
        logic [34:0] got;
        forever begin
            @(posedge clk);
            if (cyc + 2 >= MAXC) begin
                $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
                $fatal(1, "cycle budget exhausted");
            end
            vs = bus.pre_img_vsync;
            hs = bus.pre_img_hsync;
            v  = bus.pre_img_valid;
            d  = int'(bus.pre_img_data);
            if (!rst_n) begin
                m_col = 0; m_row = 0; m_hs_prev = 0; m_vs_prev = 0;
                w11 = 0; w12 = 0; w21 = 0; w22 = 0;
                exp_tab[cyc]     = '0;
                exp_tab[cyc + 1] = '0;
            end else begin
                if ((hs && !m_hs_prev) || (vs && !m_vs_prev)) m_col = 0;
                if (vs && !m_vs_prev) m_row = 0;
                if (v) begin
                    up = (m_row == 0) ? d : lb[m_col];
                    if (m_col == 0) begin
                        w21 = d; w11 = up;
                    end else begin
                        w21 = w22; w11 = w12;
                    end
                    w22 = d; w12 = up;
                    lb[m_col] = d;
                    m_col++;
                    if (m_col == HD) begin
                        m_col = 0;
                        if (m_row < VD - 1) m_row++;
                    end
                end
                exp_tab[cyc + 1] = {v, hs, vs, 8'(w11), 8'(w12), 8'(w21), 8'(w22)};
                m_hs_prev = hs;
                m_vs_prev = vs;
            end
            #1;
            got = {bus.post_img_valid, bus.post_img_hsync, bus.post_img_vsync,
                   bus.matrix_p11, bus.matrix_p12, bus.matrix_p21, bus.matrix_p22};
            check_val($sformatf("out@%0d", cyc), 64'(got), 64'(exp_tab[cyc]));
            if (log_en && bus.post_img_valid)
                log_q.push_back({bus.matrix_p11, bus.matrix_p12, bus.matrix_p21, bus.matrix_p22});
            cyc++;
        end
    end

    task automatic drive(input bit vs, input bit hs, input bit v, input logic [DW-1:0] d);
        @(negedge clk);
        bus.pre_img_vsync = vs;
        bus.pre_img_hsync = hs;
        bus.pre_img_valid = v;
        bus.pre_img_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Directed frame, pixel = 10*row+col; optional one-cycle gap before col 2 of gap_row.
    task automatic dir_frame(input int rows, input int gap_row);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        idle(1);
        for (int r = 0; r < rows; r++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            for (int c = 0; c < int'(HD); c++) begin
                if (r == gap_row && c == 2) idle(1);
                drive(1'b0, 1'b0, 1'b1, 8'(10 * r + c));
            end
        end
        idle(3);
    endtask

    function automatic logic [31:0] win(input int a, input int b, input int c, input int e);
        return {8'(a), 8'(b), 8'(c), 8'(e)};
    endfunction

    task automatic check_first_rows(input string pfx);
        check_val({pfx, "_count"}, 64'(log_q.size()), 64'(3 * HD));
        if (log_q.size() >= 3 * HD) begin
            check_val({pfx, "_r0c0"}, 64'(log_q[0]), 64'(win(0, 0, 0, 0)));
            check_val({pfx, "_r0c2"}, 64'(log_q[2]), 64'(win(1, 2, 1, 2)));
            check_val({pfx, "_r1c0"}, 64'(log_q[4]), 64'(win(0, 0, 10, 10)));
            check_val({pfx, "_r1c2"}, 64'(log_q[6]), 64'(win(1, 2, 11, 12)));
            check_val({pfx, "_r2c2"}, 64'(log_q[10]), 64'(win(11, 12, 21, 22)));
        end
    endtask

    initial begin
        int sent, hlen, rows;
        bit v;
        bus.pre_img_vsync = 1'b0;
        bus.pre_img_hsync = 1'b0;
        bus.pre_img_valid = 1'b0;
        bus.pre_img_data  = '0;

        // Reset held 10 cycles with live stimulus
        repeat (10) drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        @(negedge clk);
        rst_n = 1'b1;
        bus.pre_img_vsync = 1'b0;
        bus.pre_img_hsync = 1'b0;
        bus.pre_img_valid = 1'b0;
        idle(2);

        log_q.delete(); log_en = 1'b1;
        dir_frame(3, 2);
        log_en = 1'b0;
        check_first_rows("f1");

        log_q.delete(); log_en = 1'b1;
        dir_frame(3, -1);
        log_en = 1'b0;
        check_val("f2_count", 64'(log_q.size()), 64'(3 * HD));
        if (log_q.size() >= 2)
            check_val("f2_r0c1", 64'(log_q[1]), 64'(win(0, 1, 0, 1)));

        // Abort a frame mid row 1 with a 2-cycle reset
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        idle(1);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        for (int c = 0; c < int'(HD); c++) drive(1'b0, 1'b0, 1'b1, 8'(c));
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 8'd10);
        drive(1'b0, 1'b0, 1'b1, 8'd11);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        bus.pre_img_valid = 1'b0;
        idle(2);
        log_q.delete(); log_en = 1'b1;
        dir_frame(3, 2);
        log_en = 1'b0;
        check_first_rows("f4");

        // Randomized frames: random data, gaps, sync widths, extra rows, resets between frames
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk); rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
                @(negedge clk); rst_n = 1'b1;
                bus.pre_img_vsync = 1'b0;
                bus.pre_img_hsync = 1'b0;
                bus.pre_img_valid = 1'b0;
            end
            repeat ($urandom_range(1, 2)) drive(1'b1, 1'b0, 1'b0, 8'($urandom));
            idle($urandom_range(0, 2));
            rows = int'(VD) + (($urandom_range(0, 3) == 0) ? 1 : 0);
            for (int r = 0; r < rows; r++) begin
                sent = 0;
                hlen = $urandom_range(1, 2);
                for (int h = 0; h < hlen; h++) begin
                    v = 1'($urandom_range(0, 1));
                    drive(1'b0, 1'b1, v, 8'($urandom));
                    if (v) sent++;
                end
                while (sent < int'(HD)) begin
                    if ($urandom_range(0, 3) == 0) begin
                        drive(1'b0, 1'b0, 1'b0, 8'($urandom));
                    end else begin
                        drive(1'b0, 1'b0, 1'b1, 8'($urandom));
                        sent++;
                    end
                end
            end
            idle($urandom_range(0, 3));
        end
        idle(4);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/window_2x2_gen.md
WINDOW_2X2_GEN -- requirements
Module: window_2x2_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter H_DISP, default 800, active pixels per line (line-buffer depth).
REQ-003 SHALL have parameter V_DISP, default 600, active lines per frame.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port pre_img_vsync  input  1  frame sync, active high.
REQ-007 SHALL have port pre_img_hsync  input  1  line sync, active high.
REQ-008 SHALL have port pre_img_valid  input  1  pixel valid.
REQ-009 SHALL have port pre_img_data  input  DATA_WIDTH  pixel value.
REQ-010 SHALL have ports post_img_vsync, post_img_hsync, post_img_valid  output  1 each  syncs/valid aligned to window.
REQ-011 SHALL have ports matrix_p11, matrix_p12, matrix_p21, matrix_p22  output  DATA_WIDTH each  2x2 window (p1x previous line, p2x current line; px1 column x-1, px2 column x).

Function
REQ-012 SHALL keep a column counter (0..H_DISP-1): +1 per valid pixel, wraps to 0 after H_DISP-1, cleared on rising edge of pre_img_hsync or pre_img_vsync.
REQ-013 SHALL keep a row counter (0..V_DISP-1): +1 on column wrap, saturates at V_DISP-1, cleared on rising edge of pre_img_vsync.
REQ-014 SHALL hold one line buffer, H_DISP x DATA_WIDTH, addressed by column counter, read-before-write: on a valid cycle read old word at col then write pre_img_data at col.
REQ-015 Stage 1 (1 cycle after input): SHALL register current pixel, line-buffer read word, col==0 flag, row==0 flag, valid.
REQ-016 Stage 2 (2 cycles after input): p22 <= current pixel; p12 <= read word, or current pixel when row==0 (top-edge replication).
REQ-017 Stage 2: p21 <= previous p22 and p11 <= previous p12, except when col==0, where p21 <= new p22 and p11 <= new p12 (left-edge replication).
REQ-018 Window registers SHALL update only on stage-1 valid; otherwise hold.
REQ-019 post_img_valid, post_img_hsync, post_img_vsync SHALL equal the corresponding inputs delayed exactly 2 cycles; latency fixed at 2 regardless of data.
REQ-020 Back-to-back valid at full rate SHALL be sustained with no bubbles; gaps in pre_img_valid SHALL not advance counters or windows.
REQ-021 Line-buffer contents SHALL NOT be cleared at frame start; top-edge replication (REQ-016) masks stale data.
REQ-022 Simultaneous hsync rising edge and valid: counter clear takes priority, the pixel is treated as col 0.
REQ-023 Unsigned data only; no arithmetic on pixel values, widths preserved.

Reset
REQ-024 While rst_n==0 at a clock edge: counters, pipeline registers, all window outputs and post_img_* SHALL be 0 on the next cycle.
REQ-025 Reset mid-frame SHALL abort the frame; after release, output resumes correctly only from the next pre_img_vsync rising edge; line buffer not required to clear.
REQ-026 First cycle after rst_n rises SHALL still show all outputs 0 (2-cycle pipeline empty).

Verification (H_DISP=4, V_DISP=3, pixel = 10*row+col)
REQ-027 Reset: hold rst_n=0 10 cycles with active stimulus -> all outputs 0 throughout and 1 cycle after release.
REQ-028 Row 0 col 0 (data 0) valid at cycle N -> post_img_valid=1 at N+2, p11=p12=p21=p22=0; row 0 col 2 (data 2) -> p11=1, p12=2, p21=1, p22=2.
REQ-029 Row 1 col 0 (data 10) -> p11=0, p12=0, p21=10, p22=10; row 1 col 2 (data 12) -> p11=1, p12=2, p21=11, p22=12.
REQ-030 Row 2 with one idle cycle between col 1 and col 2 -> col 2 window p11=11, p12=12, p21=21, p22=22, emitted exactly 2 cycles after its input valid; idle cycle gives post_img_valid=0.
REQ-031 Second frame after vsync pulse -> row 0 col 1 gives p11=0, p12=1, p21=0, p22=1 (no stale frame-1 data); sync outputs are inputs delayed 2 cycles.
REQ-032 Assert rst_n=0 mid-row 1 for 2 cycles, then new frame -> frame output identical to REQ-028/029 values.
